// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode values and the iterative shifter's FSM states.
package alu_pkg;

  localparam logic [3:0] OP_SLL = 4'h5;
  localparam logic [3:0] OP_SRL = 4'h6;
  localparam logic [3:0] OP_SRA = 4'h7;
  localparam logic [3:0] OP_ROL = 4'h8;
  localparam logic [3:0] OP_ROR = 4'h9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } shift_state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) ||
           (op == OP_ROL) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves value by s positions and reports
// the last bit pushed out (for rotates, the bit that wrapped around).
module shift_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SW    = 3
) (
  input  logic [WIDTH-1:0] value,
  input  logic [3:0]       op,
  input  logic [SW-1:0]    s,
  output logic [WIDTH-1:0] result,
  output logic             bit_out
);

  logic [WIDTH:0]          ext;
  logic signed [WIDTH:0]   sext;
  logic [2*WIDTH-1:0]      dbl;

  // One guard bit beside the operand catches the last bit shifted out.
  always_comb begin
    result  = value;
    bit_out = 1'b0;
    ext     = '0;
    sext    = '0;
    dbl     = '0;
    case (op)
      OP_SLL: begin
        ext     = {1'b0, value} << s;
        result  = ext[WIDTH-1:0];
        bit_out = ext[WIDTH];
      end
      OP_SRL: begin
        ext     = {value, 1'b0} >> s;
        result  = ext[WIDTH:1];
        bit_out = ext[0];
      end
      OP_SRA: begin
        sext    = $signed({value, 1'b0}) >>> s;
        result  = sext[WIDTH:1];
        bit_out = sext[0];
      end
      OP_ROL: begin
        dbl     = {value, value} << s;
        result  = dbl[2*WIDTH-1:WIDTH];
        bit_out = dbl[WIDTH];
      end
      OP_ROR: begin
        dbl     = {value, value} >> s;
        result  = dbl[WIDTH-1:0];
        bit_out = dbl[WIDTH-1];
      end
      default: begin
        result  = value;
        bit_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_shift_seq.sv
// Iterative SLL/SRL/SRA/ROL/ROR unit moving at most STEP bits per clock,
// with valid/ready handshakes on request and result sides.
module alu_shift_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SW = $clog2(STEP) + 1;

  if ((WIDTH < 2) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
    $fatal(1, "alu_shift_seq: WIDTH must be a power of two >= 2");
  end
  if ((STEP < 1) || (STEP > WIDTH) || ((STEP & (STEP - 1)) != 0)) begin : g_bad_step
    $fatal(1, "alu_shift_seq: STEP must be a power of two in 1..WIDTH");
  end

  shift_state_e     state_reg;
  logic [AW-1:0]    rem_reg;
  logic [3:0]       op_reg;
  logic [WIDTH-1:0] val_reg;
  logic             carry_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;

  logic [AW-1:0]    amt;
  logic [AW-1:0]    rem_next;
  logic [SW-1:0]    step_s;
  logic [WIDTH-1:0] step_val;
  logic             step_bit;
  logic             unused_b;

  // Unsupported opcodes behave as a zero-length shift: result is a, carry 0.
  assign amt      = is_shift_op(op) ? b[AW-1:0] : '0;
  assign unused_b = &{1'b0, b[WIDTH-1:AW]};

  always_comb begin
    if (int'(rem_reg) > STEP) step_s = SW'(STEP);
    else                      step_s = SW'(rem_reg);
  end

  assign rem_next = rem_reg - AW'(step_s);

  shift_step #(
    .WIDTH (WIDTH),
    .SW    (SW)
  ) u_step (
    .value   (val_reg),
    .op      (op_reg),
    .s       (step_s),
    .result  (step_val),
    .bit_out (step_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      rem_reg       <= '0;
      op_reg        <= '0;
      val_reg       <= '0;
      carry_reg     <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            val_reg      <= a;
            op_reg       <= op;
            rem_reg      <= amt;
            carry_reg    <= 1'b0;
            in_ready_reg <= 1'b0;
            if (amt == '0) begin
              state_reg     <= ST_DONE;
              out_valid_reg <= 1'b1;
            end else begin
              state_reg <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          val_reg   <= step_val;
          carry_reg <= step_bit;
          rem_reg   <= rem_next;
          if (rem_next == '0) begin
            state_reg     <= ST_DONE;
            out_valid_reg <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign y         = val_reg;
  assign carry     = carry_reg;
  assign overflow  = 1'b0;
  assign zero      = (val_reg == '0);
  assign negative  = val_reg[WIDTH-1];

endmodule

// File: tb/tb_alu_shift_seq.sv
// Self-checking bench for alu_shift_seq (WIDTH=32, STEP=4): directed table,
// backpressure and reset corner cases, then random requests against a model.
module tb_alu_shift_seq;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    op = 4'h0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  y;
  logic          carry;
  logic          overflow;
  logic          zero;
  logic          negative;

  int checks = 0;
  int errors = 0;

  alu_shift_seq #(.WIDTH(W), .STEP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_y;
    logic         exp_c;
    int           exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Closed-form reference: what the shift yields after the full amount.
  task automatic model(input logic [3:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                       output logic [W-1:0] ry, output logic rc, output int rlat);
    int n;
    n = int'(mb % W);
    if (!(mop inside {4'h5, 4'h6, 4'h7, 4'h8, 4'h9})) n = 0;
    ry = ma; rc = 1'b0; rlat = (n + 3) / 4;
    if (n != 0) begin
      case (mop)
        4'h5: begin ry = ma << n; rc = ma[W-n]; end
        4'h6: begin ry = ma >> n; rc = ma[n-1]; end
        4'h7: begin ry = W'($signed(ma) >>> n); rc = ma[n-1]; end
        4'h8: begin ry = (ma << n) | (ma >> (W - n)); rc = ry[0]; end
        default: begin ry = (ma >> n) | (ma << (W - n)); rc = ry[W-1]; end
      endcase
    end
  endtask

  // Issue one request, wait for out_valid (bounded), sample, then handshake.
  task automatic run_req(input logic [3:0] rop, input logic [W-1:0] ra, input logic [W-1:0] rb,
                         output logic [W-1:0] oy, output logic oc, output logic oz,
                         output logic on, output logic ov, output int lat);
    @(negedge clk);
    op = rop; a = ra; b = rb; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clk);
      #1 lat++;
    end
    oy = y; oc = carry; oz = zero; on = negative; ov = overflow;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [3:0] rop, input logic [W-1:0] ra,
                              input logic [W-1:0] rb, input logic [W-1:0] ey, input logic ec,
                              input int elat);
    logic [W-1:0] gy;
    logic gc, gz, gn, gv;
    int glat;
    run_req(rop, ra, rb, gy, gc, gz, gn, gv, glat);
    $display("%s op=%h a=%08h b=%08h -> y=%08h c=%0b z=%0b n=%0b lat=%0d",
             tag, rop, ra, rb, gy, gc, gz, gn, glat);
    check({tag, "_y"}, gy, ey);
    check({tag, "_carry"}, {31'd0, gc}, {31'd0, ec});
    check({tag, "_zero"}, {31'd0, gz}, {31'd0, (ey == 0)});
    check({tag, "_neg"}, {31'd0, gn}, {31'd0, ey[W-1]});
    check({tag, "_ovf"}, {31'd0, gv}, 32'd0);
    check({tag, "_lat"}, W'(glat), W'(elat));
  endtask

  initial begin
    vec_t vecs[7];
    logic [W-1:0] held_y;
    logic held_c;
    logic [W-1:0] ry;
    logic rc;
    int rlat;
    int cyc;
    logic [3:0] rop;

    vecs[0] = '{4'h5, 32'h00000001, 32'd4,        32'h00000010, 1'b0, 1};
    vecs[1] = '{4'h7, 32'hFFFFFFE0, 32'd3,        32'hFFFFFFFC, 1'b0, 1};
    vecs[2] = '{4'h5, 32'h80000000, 32'd1,        32'h00000000, 1'b1, 1};
    vecs[3] = '{4'h6, 32'h80000000, 32'd31,       32'h00000001, 1'b0, 8};
    vecs[4] = '{4'h9, 32'h00000001, 32'd1,        32'h80000000, 1'b1, 1};
    vecs[5] = '{4'h8, 32'h80000001, 32'd31,       32'hC0000000, 1'b0, 8};
    vecs[6] = '{4'h5, 32'h12345678, 32'h00000020, 32'h12345678, 1'b0, 0};

    // Reset state
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_y", y, 32'd0);
    check("rst_carry", {31'd0, carry}, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    check("rst_neg", {31'd0, negative}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      check_result($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp_y, vecs[i].exp_c, vecs[i].exp_lat);

    // Backpressure: result held while out_ready low; in_valid pulse ignored.
    @(negedge clk);
    op = 4'h6; a = 32'h000000F8; b = 32'd4; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 64) begin @(posedge clk); #1 cyc++; end
    check("bp_y", y, 32'h0000000F);
    check("bp_carry", {31'd0, carry}, 32'd1);
    held_y = y; held_c = carry;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        @(negedge clk);
        op = 4'h5; a = 32'hDEADBEEF; b = 32'd8; in_valid = 1'b1;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      check("bp_hold_y", y, held_y);
      check("bp_hold_c", {31'd0, carry}, {31'd0, held_c});
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    $display("backpressure held y=%08h c=%0b for 5 cycles", y, carry);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("bp_in_ready_after", {31'd0, in_ready}, 32'd1);
    check("bp_no_capture", {31'd0, out_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1 check("bp_no_capture_later", {31'd0, out_valid}, 32'd0);

    // Reset during SHIFT of SRL by 31.
    @(negedge clk);
    op = 4'h6; a = 32'h80000000; b = 32'd31; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_y", y, 32'd0);
    check("mid_rst_carry", {31'd0, carry}, 32'd0);
    check("mid_rst_zero", {31'd0, zero}, 32'd1);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1 if (out_valid) cyc++;
    end
    check("mid_rst_no_out_valid", W'(cyc), 32'd0);
    $display("reset mid-shift: request abandoned, unit idle");
    check_result("post_rst", 4'h6, 32'h80000000, 32'd31, 32'h00000001, 1'b0, 8);

    // Random requests against the closed-form model.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: rop = 4'h5;
        1: rop = 4'h6;
        2: rop = 4'h7;
        3: rop = 4'h8;
        4: rop = 4'h9;
        default: rop = 4'($urandom_range(0, 15));
      endcase
      a = $urandom;
      b = $urandom;
      model(rop, a, b, ry, rc, rlat);
      check_result($sformatf("rnd%0d", i), rop, a, b, ry, rc, rlat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_shift_seq.md
# alu_shift_seq

Iterative, parametrised shift unit for the ALU datapath. Performs SLL/SRL/SRA plus new ROL/ROR modes, moving at most STEP bit positions per clock. Uses a valid/ready handshake on both sides. Reports the last bit shifted out on `carry`, which the combinational ALU shift path does not provide.

## Interface
- WIDTH, 32: operand/result width; power of two, ≥ 2.
- STEP, 4: maximum bit positions shifted per cycle; power of two, 1 ≤ STEP ≤ WIDTH.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request (high only in IDLE).
- op  in  4  opcode: SLL=4'h5, SRL=4'h6, SRA=4'h7, ROL=4'h8, ROR=4'h9.
- a  in  WIDTH  operand to shift.
- b  in  WIDTH  shift amount; only b[$clog2(WIDTH)-1:0] is used.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- y  out  WIDTH  result.
- carry  out  1  last bit shifted or rotated out; 0 when amount is 0.
- overflow  out  1  always 0.
- zero  out  1  y == 0.
- negative  out  1  y[WIDTH-1].

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE:**
  - in_ready=1.
  - On in_valid, capture a, op, amt=b[$clog2(WIDTH)-1:0]; clear carry.
  - If amt==0, go to DONE; otherwise go to SHIFT.
- **SHIFT:**
  - Each cycle shift by s=min(STEP, remaining); remaining -= s.
  - carry takes the last bit moved out this step.
  - When remaining reaches 0, go to DONE.
- **DONE:**
  - out_valid=1; y and flags held stable.
  - On out_ready, go to IDLE.
- Per-mode semantics for final amount n>0:
  - SLL: y=a<<n, zero fill, carry=a[WIDTH-n].
  - SRL: y=a>>n, zero fill, carry=a[n-1].
  - SRA: y=a>>>n, sign fill, carry=a[n-1].
  - ROL: y=rotate-left by n, carry=y[0].
  - ROR: y=rotate-right by n, carry=y[WIDTH-1].
- Unsupported opcode: treated as amount 0. y=a, carry=0, latency as amt==0.
- zero and negative are derived from the registered y. overflow is tied to 0.
- in_valid outside IDLE is ignored; nothing is captured or queued.

## Timing
- Reset values (asynchronous on rst_n low): state=IDLE, in_ready=1, out_valid=0, y=0, carry=0, zero=1, negative=0, overflow=0.
- Reset mid-operation abandons the request. No out_valid is produced. After release the unit is in IDLE.
- Latency: request accepted at edge k → out_valid high after edge k+ceil(amt/STEP).
  - amt=0: after edge k.
  - WIDTH=32, STEP=4, amt=31: after edge k+8.
- Result handshake completes at the edge where out_valid && out_ready. in_ready rises after that edge.
- Throughput: no overlap, one request per ceil(amt/STEP)+2 cycles minimum.
- Backpressure: y and flags do not change while out_valid && !out_ready.

## Structure
- Shared package `alu_pkg` holds:
  - opcode localparams OP_SLL/OP_SRL/OP_SRA/OP_ROL/OP_ROR, identical to the ALU opcode values;
  - the FSM state enum.
- Sub-module `shift_step`: combinational one-step shifter taking (value, op, s ≤ STEP) and returning (value', bit_out). Instantiated once per cycle path.
- Top level holds the FSM, the remaining-count register ($clog2(WIDTH) bits), the operand/result register and the flag logic.
- Parameter legality is checked at elaboration; an illegal WIDTH/STEP is a fatal error.

## Test plan
All scenarios use WIDTH=32, STEP=4.
- SLL a=0x00000001, b=4 → y=0x00000010, C=0, Z=0, N=0, V=0; out_valid one edge after accept.
- SRA a=0xFFFFFFE0, b=3 → y=0xFFFFFFFC, C=0, N=1.
- SLL a=0x80000000, b=1 → y=0, C=1, Z=1.
- SRL a=0x80000000, b=31 → y=0x00000001, C=0, latency 8.
- ROR a=0x00000001, b=1 → y=0x80000000, C=1, N=1.
- ROL a=0x80000001, b=31 → y=0xC0000000, C=0, latency 8.
- SLL a=0x12345678, b=0x20 (used amount 0) → y=0x12345678, C=0, out_valid after the accept edge.
- Hold out_ready low for 5 cycles after out_valid:
  - y and flags stay stable, in_ready stays 0;
  - a pulsed in_valid is not captured;
  - after the handshake edge, in_ready=1.
- Drive rst_n low during SHIFT of an SRL b=31:
  - outputs return immediately to reset values;
  - no out_valid appears;
  - the next request completes normally.
